// File: rtl/mult_div_unit_pkg.sv
// Shared multiply/divide definitions: MDOp encodings and default busy-cycle counts,
// also used by the controller and hazard unit.
package mult_div_unit_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  localparam int unsigned MD_MULT_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF  = 10;
  localparam int unsigned MD_CNT_W           = 16;

  function automatic logic md_is_arith(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_calc.sv
// Combinational 64-bit {HI,LO} result generation for mult/multu/div/divu,
// plus a divide-by-zero flag for div/divu.
module md_calc
  import mult_div_unit_pkg::*;
(
  input  md_op_e      op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] result_o,
  output logic        div_zero_o
);

  logic        sgn_div;
  logic [31:0] mag_a, mag_b, divisor, quo, rem, quo_s, rem_s;
  logic [63:0] a64, b64, prod;

  always_comb begin
    sgn_div = (op_i == MD_DIV);
    // Divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow.
    mag_a   = (sgn_div && a_i[31]) ? (32'd0 - a_i) : a_i;
    mag_b   = (sgn_div && b_i[31]) ? (32'd0 - b_i) : b_i;
    divisor = (b_i == '0) ? 32'd1 : mag_b;
    quo     = mag_a / divisor;
    rem     = mag_a % divisor;
    quo_s   = (sgn_div && (a_i[31] ^ b_i[31])) ? (32'd0 - quo) : quo;
    rem_s   = (sgn_div && a_i[31]) ? (32'd0 - rem) : rem;

    a64  = (op_i == MD_MULT) ? {{32{a_i[31]}}, a_i} : {32'd0, a_i};
    b64  = (op_i == MD_MULT) ? {{32{b_i[31]}}, b_i} : {32'd0, b_i};
    prod = a64 * b64;

    result_o   = md_is_div(op_i) ? {rem_s, quo_s} : prod;
    div_zero_o = md_is_div(op_i) && (b_i == '0);
  end

endmodule

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit: owns HI/LO, runs multi-cycle mult/div with a
// BUSY down-counter, and services mthi/mtlo/mfhi/mflo.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        BUSY,
  output logic [31:0] MDdata_E
);

  md_op_e              op;
  logic [63:0]         calc_res;
  logic                calc_dz;

  logic [31:0]         hi_q, hi_d, lo_q, lo_d;
  logic [31:0]         phi_q, phi_d, plo_q, plo_d;
  logic                pdz_q, pdz_d;
  logic                busy_q, busy_d;
  logic [MD_CNT_W-1:0] cnt_q, cnt_d;

  assign op = md_op_e'(MDOp);

  md_calc u_calc (
    .op_i       (op),
    .a_i        (A),
    .b_i        (B),
    .result_o   (calc_res),
    .div_zero_o (calc_dz)
  );

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    phi_d  = phi_q;
    plo_d  = plo_q;
    pdz_d  = pdz_q;
    busy_d = busy_q;
    cnt_d  = cnt_q;

    if (busy_q) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q <= MD_CNT_W'(1)) begin
        busy_d = 1'b0;
        cnt_d  = '0;
        if (!pdz_q) begin
          hi_d = phi_q;
          lo_d = plo_q;
        end
      end
    end else if (Start && md_is_arith(op)) begin
      phi_d  = calc_res[63:32];
      plo_d  = calc_res[31:0];
      pdz_d  = calc_dz;
      busy_d = 1'b1;
      cnt_d  = md_is_div(op) ? MD_CNT_W'(DIV_CYCLES) : MD_CNT_W'(MULT_CYCLES);
    end else if (!Start) begin
      if (op == MD_MTHI) hi_d = A;
      if (op == MD_MTLO) lo_d = A;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      phi_q  <= '0;
      plo_q  <= '0;
      pdz_q  <= 1'b0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      phi_q  <= phi_d;
      plo_q  <= plo_d;
      pdz_q  <= pdz_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign BUSY     = busy_q;
  assign MDdata_E = (op == MD_MFHI) ? hi_q :
                    (op == MD_MFLO) ? lo_q : '0;

endmodule
